// File: rtl/alu_pkg.sv
// Shared constants, FSM state type and the single-cycle RV32I datapath
// for the execute-stage arithmetic unit.
package alu_pkg;

  localparam int XLEN = 32;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0011;
  localparam logic [3:0] ALU_SLL  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_XOR  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;

  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } state_t;

  typedef struct packed {
    logic [XLEN-1:0] result;
    logic            illegal;
  } base_res_t;

  // Undefined codes yield a zero result flagged illegal.
  function automatic base_res_t alu_base(input logic [3:0]      ctrl,
                                         input logic [XLEN-1:0] a,
                                         input logic [XLEN-1:0] b);
    base_res_t r;
    r.result  = '0;
    r.illegal = 1'b0;
    case (ctrl)
      ALU_AND:  r.result = a & b;
      ALU_OR:   r.result = a | b;
      ALU_ADD:  r.result = a + b;
      ALU_SUB:  r.result = a - b;
      ALU_SLL:  r.result = a << b[4:0];
      ALU_SLT:  r.result = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      ALU_SLTU: r.result = {{(XLEN-1){1'b0}}, a < b};
      ALU_XOR:  r.result = a ^ b;
      ALU_SRL:  r.result = a >> b[4:0];
      ALU_SRA:  r.result = $signed(a) >>> b[4:0];
      default:  r.illegal = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/div_iter.sv
// Restoring radix-2 divider on unsigned magnitudes: one quotient bit per
// cycle, done pulses for one cycle after the 32nd step.
module div_iter
  import alu_pkg::*;
(
  input  logic            clk,
  input  logic            srst,
  input  logic            start,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            done,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  logic [XLEN-1:0] quo_reg;
  logic [XLEN-1:0] rem_reg;
  logic [XLEN-1:0] dvs_reg;
  logic [4:0]      cnt_reg;
  logic            active_reg;
  logic            done_reg;
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   trial;

  // The partial remainder stays below the divisor, so a borrow out of
  // bit XLEN is exactly "trial subtraction went negative".
  assign shifted = {rem_reg, quo_reg[XLEN-1]};
  assign trial   = shifted - {1'b0, dvs_reg};

  always_ff @(posedge clk) begin
    if (srst) begin
      quo_reg    <= '0;
      rem_reg    <= '0;
      dvs_reg    <= '0;
      cnt_reg    <= '0;
      active_reg <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (start) begin
        quo_reg    <= dividend;
        rem_reg    <= '0;
        dvs_reg    <= divisor;
        cnt_reg    <= '0;
        active_reg <= 1'b1;
      end else if (active_reg) begin
        if (trial[XLEN]) begin
          rem_reg <= shifted[XLEN-1:0];
          quo_reg <= {quo_reg[XLEN-2:0], 1'b0};
        end else begin
          rem_reg <= trial[XLEN-1:0];
          quo_reg <= {quo_reg[XLEN-2:0], 1'b1};
        end
        cnt_reg <= cnt_reg + 5'd1;
        if (cnt_reg == 5'd31) begin
          active_reg <= 1'b0;
          done_reg   <= 1'b1;
        end
      end
    end
  end

  assign done      = done_reg;
  assign quotient  = quo_reg;
  assign remainder = rem_reg;

endmodule

// File: rtl/exec_alu_unit.sv
// Execute-stage arithmetic unit: single-cycle RV32I ops, pipelined RV32M
// multiply, iterative divide, registered result behind a valid/ready pair.
module exec_alu_unit #(
  parameter int XLEN        = 32,
  parameter int MUL_LATENCY = 2
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            IN_VALID,
  output logic            IN_READY,
  input  logic [3:0]      ALU_CTRL,
  input  logic            MD_EN,
  input  logic [2:0]      MD_OP,
  input  logic [XLEN-1:0] DATA1,
  input  logic [XLEN-1:0] DATA2,
  output logic            OUT_VALID,
  input  logic            OUT_READY,
  output logic [XLEN-1:0] RESULT,
  output logic            ZERO,
  output logic            ILLEGAL,
  output logic            BUSY
);
  import alu_pkg::*;

  localparam logic [1:0]      MUL_CNT_INIT = 2'(MUL_LATENCY > 1 ? MUL_LATENCY - 2 : 0);
  localparam logic [XLEN-1:0] INT_MIN      = {1'b1, {(XLEN-1){1'b0}}};

  state_t          state_reg, state_next;
  logic            out_valid_reg;
  logic [XLEN-1:0] result_reg;
  logic            zero_reg;
  logic            illegal_reg;
  logic [1:0]      mul_cnt_reg;
  logic            div_rem_reg, neg_q_reg, neg_r_reg;

  logic            in_ready, accept;
  logic            is_mul, is_div, div_signed;
  logic            div_by_zero, div_ovf, div_special;
  logic            div_start, div_done;
  logic [XLEN-1:0] a_mag, b_mag, div_q, div_r, q_fix, r_fix, spec_res;
  logic [2*XLEN-1:0] mul_a, mul_b, mul_prod;
  logic [XLEN-1:0] mul_sel, mul_out;
  base_res_t       base_res;
  logic            wr_en, wr_illegal;
  logic [XLEN-1:0] wr_data;

  assign in_ready = (state_reg == IDLE) && (!out_valid_reg || OUT_READY);
  assign accept   = IN_VALID && in_ready;
  assign is_mul   = MD_EN && !MD_OP[2];
  assign is_div   = MD_EN && MD_OP[2];
  assign div_signed = !MD_OP[0];

  assign base_res = alu_base(ALU_CTRL, DATA1, DATA2);

  // Low 2*XLEN bits of the product of sign/zero-extended operands equal
  // the low bits of the 33x33 signed product.
  assign mul_a    = {{XLEN{DATA1[XLEN-1] && (MD_OP != MD_MULHU)}}, DATA1};
  assign mul_b    = {{XLEN{DATA2[XLEN-1] && (MD_OP == MD_MUL || MD_OP == MD_MULH)}}, DATA2};
  assign mul_prod = mul_a * mul_b;
  assign mul_sel  = (MD_OP == MD_MUL) ? mul_prod[XLEN-1:0] : mul_prod[2*XLEN-1:XLEN];

  generate
    if (MUL_LATENCY == 1) begin : g_mul_comb
      assign mul_out = mul_sel;
    end else begin : g_mul_pipe
      logic [XLEN-1:0] pipe_reg [0:MUL_LATENCY-2];
      for (genvar gi = 0; gi < MUL_LATENCY - 1; gi++) begin : g_stage
        if (gi == 0) begin : g_first
          always_ff @(posedge CLK) pipe_reg[0] <= mul_sel;
        end else begin : g_next
          always_ff @(posedge CLK) pipe_reg[gi] <= pipe_reg[gi-1];
        end
      end
      assign mul_out = pipe_reg[MUL_LATENCY-2];
    end
  endgenerate

  assign div_by_zero = (DATA2 == '0);
  assign div_ovf     = div_signed && (DATA1 == INT_MIN) && (DATA2 == '1);
  assign div_special = div_by_zero || div_ovf;
  assign spec_res    = MD_OP[1] ? (div_by_zero ? DATA1 : '0)
                                : (div_by_zero ? '1 : INT_MIN);
  assign a_mag = (div_signed && DATA1[XLEN-1]) ? -DATA1 : DATA1;
  assign b_mag = (div_signed && DATA2[XLEN-1]) ? -DATA2 : DATA2;

  div_iter u_div (
    .clk       (CLK),
    .srst      (RESET),
    .start     (div_start),
    .dividend  (a_mag),
    .divisor   (b_mag),
    .done      (div_done),
    .quotient  (div_q),
    .remainder (div_r)
  );

  assign q_fix = neg_q_reg ? -div_q : div_q;
  assign r_fix = neg_r_reg ? -div_r : div_r;

  always_ff @(posedge CLK) begin
    if (RESET) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (accept && is_mul && (MUL_LATENCY > 1))   state_next = MUL;
        else if (accept && is_div && !div_special)   state_next = DIV;
      end
      MUL:     if (mul_cnt_reg == 2'd0) state_next = IDLE;
      DIV:     if (div_done)            state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    wr_en      = 1'b0;
    wr_data    = '0;
    wr_illegal = 1'b0;
    div_start  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          if (!MD_EN) begin
            wr_en      = 1'b1;
            wr_data    = base_res.result;
            wr_illegal = base_res.illegal;
          end else if (is_mul) begin
            if (MUL_LATENCY == 1) begin
              wr_en   = 1'b1;
              wr_data = mul_out;
            end
          end else if (div_special) begin
            wr_en   = 1'b1;
            wr_data = spec_res;
          end else begin
            div_start = 1'b1;
          end
        end
      end
      MUL: begin
        if (mul_cnt_reg == 2'd0) begin
          wr_en   = 1'b1;
          wr_data = mul_out;
        end
      end
      DIV: begin
        if (div_done) begin
          wr_en   = 1'b1;
          wr_data = div_rem_reg ? r_fix : q_fix;
        end
      end
      default: ;
    endcase
  end

  // A multi-cycle op is only accepted once the output slot is free, so a
  // completing MUL/DIV never overwrites an unconsumed result.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      out_valid_reg <= 1'b0;
      result_reg    <= '0;
      zero_reg      <= 1'b0;
      illegal_reg   <= 1'b0;
      mul_cnt_reg   <= 2'd0;
      div_rem_reg   <= 1'b0;
      neg_q_reg     <= 1'b0;
      neg_r_reg     <= 1'b0;
    end else begin
      if (wr_en) begin
        out_valid_reg <= 1'b1;
        result_reg    <= wr_data;
        zero_reg      <= (wr_data == '0);
        illegal_reg   <= wr_illegal;
      end else if (OUT_READY) begin
        out_valid_reg <= 1'b0;
      end
      if (accept && is_mul)
        mul_cnt_reg <= MUL_CNT_INIT;
      else if (state_reg == MUL && mul_cnt_reg != 2'd0)
        mul_cnt_reg <= mul_cnt_reg - 2'd1;
      if (div_start) begin
        div_rem_reg <= MD_OP[1];
        neg_q_reg   <= div_signed && (DATA1[XLEN-1] ^ DATA2[XLEN-1]);
        neg_r_reg   <= div_signed && DATA1[XLEN-1];
      end
    end
  end

  assign IN_READY  = in_ready;
  assign OUT_VALID = out_valid_reg;
  assign RESULT    = result_reg;
  assign ZERO      = zero_reg;
  assign ILLEGAL   = illegal_reg;
  assign BUSY      = (state_reg != IDLE);

endmodule

// File: tb/tb_exec_alu_unit.sv
// Directed, table-driven bench for exec_alu_unit plus hand-written
// sequences for back-to-back issue, backpressure and mid-divide reset.
module tb_exec_alu_unit;

  localparam int ML  = 2;
  localparam int DIV_LAT = 33;

  logic        CLK = 1'b0;
  logic        RESET, IN_VALID, IN_READY, MD_EN, OUT_VALID, OUT_READY;
  logic        ZERO, ILLEGAL, BUSY;
  logic [3:0]  ALU_CTRL;
  logic [2:0]  MD_OP;
  logic [31:0] DATA1, DATA2, RESULT;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  exec_alu_unit #(.XLEN(32), .MUL_LATENCY(ML)) dut (
    .CLK(CLK), .RESET(RESET), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .ALU_CTRL(ALU_CTRL), .MD_EN(MD_EN), .MD_OP(MD_OP),
    .DATA1(DATA1), .DATA2(DATA2), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .RESULT(RESULT), .ZERO(ZERO), .ILLEGAL(ILLEGAL), .BUSY(BUSY)
  );

  typedef struct {
    bit        md_en;
    bit [2:0]  md_op;
    bit [3:0]  ctrl;
    bit [31:0] d1;
    bit [31:0] d2;
    bit [31:0] res;
    bit        ill;
    int        lat;   // edges after the acceptance edge until OUT_VALID
  } vec_t;

  vec_t vecs [28];

  function automatic vec_t mk(bit md_en, bit [2:0] md_op, bit [3:0] ctrl,
                              bit [31:0] d1, bit [31:0] d2, bit [31:0] res,
                              bit ill, int lat);
    vec_t v;
    v.md_en = md_en; v.md_op = md_op; v.ctrl = ctrl;
    v.d1 = d1; v.d2 = d2; v.res = res; v.ill = ill; v.lat = lat;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input bit md_en, input bit [2:0] md_op, input bit [3:0] ctrl,
                       input bit [31:0] d1, input bit [31:0] d2);
    IN_VALID = 1'b1; MD_EN = md_en; MD_OP = md_op; ALU_CTRL = ctrl;
    DATA1 = d1; DATA2 = d2;
  endtask

  task automatic do_op(input vec_t v, input int idx);
    int  guard;
    int  lat;
    bit  stall_ok;
    @(negedge CLK);
    drive(v.md_en, v.md_op, v.ctrl, v.d1, v.d2);
    guard = 0;
    while (!IN_READY && guard < 100) begin
      @(negedge CLK);
      guard++;
    end
    chk($sformatf("v%0d accept_timeout", idx), 32'(guard < 100), 32'd1);
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    lat = 0;
    stall_ok = 1'b1;
    while (!OUT_VALID && lat < 60) begin
      if (!BUSY || IN_READY) stall_ok = 1'b0;
      @(posedge CLK); #1;
      lat++;
    end
    $display("op %0d: md_en=%0b md_op=%0d ctrl=%0h d1=%08h d2=%08h -> result=%08h zero=%0b illegal=%0b lat=%0d",
             idx, v.md_en, v.md_op, v.ctrl, v.d1, v.d2, RESULT, ZERO, ILLEGAL, lat);
    chk($sformatf("v%0d latency", idx), lat, v.lat);
    chk($sformatf("v%0d result", idx), RESULT, v.res);
    chk($sformatf("v%0d zero", idx), 32'(ZERO), 32'(v.res == 32'd0));
    chk($sformatf("v%0d illegal", idx), 32'(ILLEGAL), 32'(v.ill));
    chk($sformatf("v%0d busy_after", idx), 32'(BUSY), 32'd0);
    if (v.lat > 0) chk($sformatf("v%0d stall", idx), 32'(stall_ok), 32'd1);
  endtask

  initial begin
    int seen;

    // Base ops: md_en=0
    vecs[0]  = mk(0, 3'd0, 4'h2, 32'd5,        32'd7,        32'h0000000C, 0, 0);  // ADD
    vecs[1]  = mk(0, 3'd0, 4'h9, 32'h80000000, 32'h00000024, 32'hF8000000, 0, 0);  // SRA by 4
    vecs[2]  = mk(0, 3'd0, 4'h6, 32'd1,        32'hFFFFFFFF, 32'd1,        0, 0);  // SLTU
    vecs[3]  = mk(0, 3'd0, 4'h5, 32'd1,        32'hFFFFFFFF, 32'd0,        0, 0);  // SLT
    vecs[4]  = mk(0, 3'd0, 4'h0, 32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 0, 0);  // AND
    vecs[5]  = mk(0, 3'd0, 4'h1, 32'h00000F00, 32'h000000F0, 32'h00000FF0, 0, 0);  // OR
    vecs[6]  = mk(0, 3'd0, 4'h7, 32'hFFFF0000, 32'hFF00FF00, 32'h00FFFF00, 0, 0);  // XOR
    vecs[7]  = mk(0, 3'd0, 4'h4, 32'd1,        32'h00000021, 32'd2,        0, 0);  // SLL by 1
    vecs[8]  = mk(0, 3'd0, 4'h8, 32'h80000000, 32'd31,       32'd1,        0, 0);  // SRL
    vecs[9]  = mk(0, 3'd0, 4'h3, 32'd0,        32'd1,        32'hFFFFFFFF, 0, 0);  // SUB wraps
    vecs[10] = mk(0, 3'd0, 4'hF, 32'h12345678, 32'h9ABCDEF0, 32'd0,        1, 0);  // illegal
    vecs[11] = mk(0, 3'd0, 4'hA, 32'hFFFFFFFF, 32'd1,        32'd0,        1, 0);  // illegal
    // Multiply
    vecs[12] = mk(1, 3'd1, 4'h0, 32'h80000000, 32'h80000000, 32'h40000000, 0, ML-1); // MULH
    vecs[13] = mk(1, 3'd3, 4'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 0, ML-1); // MULHU
    vecs[14] = mk(1, 3'd0, 4'h0, 32'hFFFFFFFF, 32'd3,        32'hFFFFFFFD, 0, ML-1); // MUL
    vecs[15] = mk(1, 3'd2, 4'h0, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 0, ML-1); // MULHSU
    vecs[16] = mk(1, 3'd0, 4'hF, 32'd6,        32'd7,        32'd42,       0, ML-1); // MUL, ctrl ignored
    // Iterative divide
    vecs[17] = mk(1, 3'd4, 4'h0, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 0, DIV_LAT); // DIV -7,2
    vecs[18] = mk(1, 3'd6, 4'h0, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 0, DIV_LAT); // REM -7,2
    vecs[19] = mk(1, 3'd5, 4'h0, 32'd100,      32'd7,        32'd14,       0, DIV_LAT); // DIVU
    vecs[20] = mk(1, 3'd7, 4'h0, 32'd100,      32'd7,        32'd2,        0, DIV_LAT); // REMU
    vecs[21] = mk(1, 3'd4, 4'h0, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 0, DIV_LAT); // DIV 7,-2
    vecs[22] = mk(1, 3'd6, 4'h0, 32'd7,        32'hFFFFFFFE, 32'd1,        0, DIV_LAT); // REM 7,-2
    vecs[23] = mk(1, 3'd5, 4'h0, 32'h80000000, 32'hFFFFFFFF, 32'd0,        0, DIV_LAT); // DIVU, no overflow case
    // Special cases
    vecs[24] = mk(1, 3'd5, 4'h0, 32'd9,        32'd0,        32'hFFFFFFFF, 0, 0);  // DIVU by 0
    vecs[25] = mk(1, 3'd6, 4'h0, 32'd7,        32'd0,        32'd7,        0, 0);  // REM by 0
    vecs[26] = mk(1, 3'd4, 4'h0, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0, 0);  // DIV overflow
    vecs[27] = mk(1, 3'd6, 4'h0, 32'h80000000, 32'hFFFFFFFF, 32'd0,        0, 0);  // REM overflow

    RESET = 1'b1; IN_VALID = 1'b0; OUT_READY = 1'b1;
    MD_EN = 1'b0; MD_OP = 3'd0; ALU_CTRL = 4'h0; DATA1 = '0; DATA2 = '0;
    repeat (3) @(posedge CLK);
    #1;
    chk("reset out_valid", 32'(OUT_VALID), 32'd0);
    chk("reset result", RESULT, 32'd0);
    chk("reset zero", 32'(ZERO), 32'd0);
    chk("reset illegal", 32'(ILLEGAL), 32'd0);
    chk("reset busy", 32'(BUSY), 32'd0);
    @(negedge CLK);
    RESET = 1'b0;

    for (int i = 0; i < 28; i++) do_op(vecs[i], i);

    // Back-to-back base ops: no bubble between the two results
    @(negedge CLK);
    drive(0, 3'd0, 4'h2, 32'd5, 32'd7);
    chk("b2b ready1", 32'(IN_READY), 32'd1);
    @(posedge CLK); #1;
    drive(0, 3'd0, 4'h3, 32'd7, 32'd7);
    chk("b2b valid1", 32'(OUT_VALID), 32'd1);
    chk("b2b result1", RESULT, 32'h0000000C);
    chk("b2b zero1", 32'(ZERO), 32'd0);
    chk("b2b ready2", 32'(IN_READY), 32'd1);
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    $display("b2b: second result=%08h zero=%0b", RESULT, ZERO);
    chk("b2b valid2", 32'(OUT_VALID), 32'd1);
    chk("b2b result2", RESULT, 32'd0);
    chk("b2b zero2", 32'(ZERO), 32'd1);
    @(posedge CLK); #1;
    chk("b2b drained", 32'(OUT_VALID), 32'd0);

    // Backpressure: result held, new op refused until the slot drains
    @(negedge CLK);
    OUT_READY = 1'b0;
    drive(0, 3'd0, 4'h2, 32'd5, 32'd7);
    @(posedge CLK); #1;
    drive(0, 3'd0, 4'h3, 32'd1, 32'd1);
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("bp valid c%0d", c), 32'(OUT_VALID), 32'd1);
      chk($sformatf("bp result c%0d", c), RESULT, 32'h0000000C);
      chk($sformatf("bp ready c%0d", c), 32'(IN_READY), 32'd0);
      @(posedge CLK); #1;
    end
    @(negedge CLK);
    OUT_READY = 1'b1;
    #1;
    chk("bp ready released", 32'(IN_READY), 32'd1);
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    $display("bp: released result=%08h zero=%0b", RESULT, ZERO);
    chk("bp next result", RESULT, 32'd0);
    chk("bp next zero", 32'(ZERO), 32'd1);
    @(posedge CLK); #1;

    // Reset in the middle of a divide discards it
    @(negedge CLK);
    drive(1, 3'd5, 4'h0, 32'd100, 32'd7);
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    repeat (10) @(posedge CLK);
    #1;
    chk("rst mid busy before", 32'(BUSY), 32'd1);
    @(negedge CLK);
    RESET = 1'b1;
    @(posedge CLK); #1;
    RESET = 1'b0;
    $display("reset mid-divide: out_valid=%0b busy=%0b in_ready=%0b", OUT_VALID, BUSY, IN_READY);
    chk("rst mid out_valid", 32'(OUT_VALID), 32'd0);
    chk("rst mid busy", 32'(BUSY), 32'd0);
    chk("rst mid in_ready", 32'(IN_READY), 32'd1);
    seen = 0;
    repeat (40) begin
      @(posedge CLK); #1;
      if (OUT_VALID) seen++;
    end
    chk("rst mid discarded", seen, 0);
    do_op(vecs[0], 100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
